// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
//   Sequencing controller for the calculator's shared arithmetic datapath.
//   One request is taken at a time. ADD, SUB and the memory ops finish in one cycle.
//   MUL is a shift-add that retires one multiplier bit per cycle.
//   DIV is a restoring divide that produces one quotient bit per cycle.
//   A result is held until the consumer accepts it.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   reqValid/reqReady   request handshake (opcode, operand1, operand2)
//   resValid/resReady   result handshake (result, error)
//   memValue            calculator memory register
//   busy                high while iterating MUL or DIV
module calc_op_sequencer #(
  parameter int OP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [2:0]        opcode,
  input  logic [OP_W-1:0]   operand1,
  input  logic [OP_W-1:0]   operand2,
  output logic              resValid,
  input  logic              resReady,
  output logic [2*OP_W-1:0] result,
  output logic              error,
  output logic [2*OP_W-1:0] memValue,
  output logic              busy
);
  localparam int RW = 2 * OP_W;
  localparam int CW = (OP_W > 1) ? $clog2(OP_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010,
                         OP_DIV = 3'b011, OP_MST = 3'b100, OP_MRC = 3'b101,
                         OP_MCL = 3'b110;

  state_t          state_q, state_d;
  logic [RW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [OP_W-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Partial remainder carries one spare bit so the trial shift never overflows.
  logic [OP_W:0]   rem_q, rem_d;
  logic [OP_W-1:0] quot_q, quot_d, dvsr_q, dvsr_d;
  logic [RW-1:0]   result_q, result_d, mem_q, mem_d, last_q, last_d;
  logic            error_q, error_d;

  logic [OP_W:0]   trial, diff;
  logic            ge;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    error_d  = error_q;
    mem_d    = mem_q;
    last_d   = last_q;
    // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    trial    = (rem_q << 1) | (OP_W+1)'(quot_q[OP_W-1]);
    diff     = trial - {1'b0, dvsr_q};
    ge       = (trial >= {1'b0, dvsr_q});

    case (state_q)
      S_IDLE: if (reqValid) begin
        state_d = S_DONE;
        error_d = 1'b0;
        case (opcode)
          OP_ADD: result_d = RW'(operand1) + RW'(operand2);
          OP_SUB: result_d = RW'(operand1) - RW'(operand2);
          OP_MUL: begin
            acc_d    = '0;
            mcand_d  = RW'(operand1);
            mplier_d = operand2;
            cnt_d    = CW'(OP_W - 1);
            state_d  = S_MUL;
          end
          OP_DIV: begin
            if (operand2 == '0) begin
              result_d = '0;
              error_d  = 1'b1;
            end else begin
              rem_d   = '0;
              quot_d  = operand1;
              dvsr_d  = operand2;
              cnt_d   = CW'(OP_W - 1);
              state_d = S_DIV;
            end
          end
          OP_MST: begin
            mem_d    = last_q;
            result_d = last_q;
          end
          OP_MRC: result_d = mem_q;
          OP_MCL: begin
            mem_d    = '0;
            result_d = '0;
          end
          default: begin
            result_d = '0;
            error_d  = 1'b1;
          end
        endcase
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = acc_d;
          error_d  = 1'b0;
        end
      end
      S_DIV: begin
        rem_d  = ge ? diff : trial;
        quot_d = {quot_q[OP_W-2:0], ge};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = {rem_d[OP_W-1:0], quot_d};
          error_d  = 1'b0;
        end
      end
      S_DONE: if (resReady) begin
        state_d = S_IDLE;
        if (!error_q) last_d = result_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      mem_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      error_q  <= error_d;
      mem_q    <= mem_d;
      last_q   <= last_d;
    end
  end

  assign reqReady = (state_q == S_IDLE);
  assign resValid = (state_q == S_DONE);
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign result   = result_q;
  assign error    = error_q;
  assign memValue = mem_q;
endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reqValid = 1'b0, reqReady, resValid, resReady = 1'b0, error, busy;
  logic [2:0] opcode = '0;
  logic [3:0] operand1 = '0, operand2 = '0;
  logic [7:0] result, memValue;
  int n_cmp = 0, n_fail = 0;

  calc_op_sequencer #(.OP_W(4)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .resValid(resValid), .resReady(resReady), .result(result),
    .error(error), .memValue(memValue), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents one request across a single rising edge (the accept edge).
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    opcode = op; operand1 = a; operand2 = b; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic accept_result();
    resReady = 1'b1;
    @(posedge clk); #1;
    resReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({reqReady, resValid, error, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got %b want 1000", {reqReady, resValid, error, busy});
    end
    n_cmp++;
    if (result !== 8'h00 || memValue !== 8'h00) begin
      n_fail++; $display("FAIL reset_data got res=%h mem=%h want 00/00", result, memValue);
    end
  endtask

  task automatic test_add();
    resReady = 1'b1;
    issue(3'b000, 4'd9, 4'd7);
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b1 || result !== 8'h10 || error !== 1'b0 || reqReady !== 1'b0) begin
      n_fail++; $display("FAIL add_9_7 got v=%b r=%h e=%b rdy=%b want 1/10/0/0", resValid, result, error, reqReady);
    end
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b0 || reqReady !== 1'b1) begin
      n_fail++; $display("FAIL add_after_accept got v=%b rdy=%b want 0/1", resValid, reqReady);
    end
    resReady = 1'b0;
  endtask

  task automatic test_mul();
    issue(3'b010, 4'd15, 4'd15);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || resValid !== 1'b0 || reqReady !== 1'b0) begin
        n_fail++; $display("FAIL mul_busy_%0d got busy=%b v=%b rdy=%b want 1/0/0", i, busy, resValid, reqReady);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b1 || busy !== 1'b0 || result !== 8'hE1 || error !== 1'b0) begin
      n_fail++; $display("FAIL mul_15x15 got v=%b busy=%b r=%h e=%b want 1/0/e1/0", resValid, busy, result, error);
    end
    accept_result();
    issue(3'b010, 4'd0, 4'd13);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b0) begin
      n_fail++; $display("FAIL mul_0x13_early got v=%b want 0", resValid);
    end
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b1 || result !== 8'h00) begin
      n_fail++; $display("FAIL mul_0x13 got v=%b r=%h want 1/00", resValid, result);
    end
    accept_result();
  endtask

  task automatic test_div();
    issue(3'b011, 4'd13, 4'd4);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || resValid !== 1'b0) begin
      n_fail++; $display("FAIL div_busy got busy=%b v=%b want 1/0", busy, resValid);
    end
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b1 || result !== 8'h13 || error !== 1'b0) begin
      n_fail++; $display("FAIL div_13_4 got v=%b r=%h e=%b want 1/13/0", resValid, result, error);
    end
    accept_result();
    issue(3'b011, 4'd7, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b1 || error !== 1'b1 || result !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL div_by_zero got v=%b e=%b r=%h busy=%b want 1/1/00/0", resValid, error, result, busy);
    end
    accept_result();
    // The error result must not replace the last good result (8'h13).
    issue(3'b100, 4'd0, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (result !== 8'h13 || memValue !== 8'h13) begin
      n_fail++; $display("FAIL div0_last_kept got r=%h mem=%h want 13/13", result, memValue);
    end
    accept_result();
  endtask

  task automatic test_sub_hold();
    issue(3'b001, 4'd3, 4'd5);
    opcode = 3'b000; operand1 = 4'd1; operand2 = 4'd1; reqValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resValid !== 1'b1 || result !== 8'hFE || error !== 1'b0 || reqReady !== 1'b0) begin
        n_fail++; $display("FAIL sub_hold_%0d got v=%b r=%h e=%b rdy=%b want 1/fe/0/0", i, resValid, result, error, reqReady);
      end
    end
    reqValid = 1'b0;
    accept_result();
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b0 || result !== 8'hFE || reqReady !== 1'b1) begin
      n_fail++; $display("FAIL sub_after got v=%b r=%h rdy=%b want 0/fe/1", resValid, result, reqReady);
    end
  endtask

  task automatic test_mem();
    issue(3'b010, 4'd6, 4'd7);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (result !== 8'h2A) begin
      n_fail++; $display("FAIL mul_6x7 got %h want 2a", result);
    end
    accept_result();
    issue(3'b100, 4'd0, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (memValue !== 8'h2A || result !== 8'h2A) begin
      n_fail++; $display("FAIL mstore got mem=%h r=%h want 2a/2a", memValue, result);
    end
    accept_result();
    issue(3'b101, 4'd0, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (result !== 8'h2A) begin
      n_fail++; $display("FAIL mrecall_2a got %h want 2a", result);
    end
    accept_result();
    issue(3'b110, 4'd0, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (memValue !== 8'h00 || result !== 8'h00) begin
      n_fail++; $display("FAIL mclear got mem=%h r=%h want 00/00", memValue, result);
    end
    accept_result();
    issue(3'b101, 4'd0, 4'd0);
    @(negedge clk);
    n_cmp++;
    if (result !== 8'h00 || error !== 1'b0) begin
      n_fail++; $display("FAIL mrecall_0 got r=%h e=%b want 00/0", result, error);
    end
    accept_result();
  endtask

  task automatic test_reset_mid_mul();
    issue(3'b000, 4'd3, 4'd4);
    accept_result();
    issue(3'b100, 4'd0, 4'd0);
    accept_result();
    @(negedge clk);
    n_cmp++;
    if (memValue !== 8'h07) begin
      n_fail++; $display("FAIL mem_before_rst got %h want 07", memValue);
    end
    issue(3'b010, 4'd5, 4'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || resValid !== 1'b0 || reqReady !== 1'b1 || memValue !== 8'h00 || result !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_mul got busy=%b v=%b rdy=%b mem=%h r=%h want 0/0/1/00/00", busy, resValid, reqReady, memValue, result);
    end
    issue(3'b111, 4'd9, 4'd9);
    @(negedge clk);
    n_cmp++;
    if (resValid !== 1'b1 || error !== 1'b1 || result !== 8'h00) begin
      n_fail++; $display("FAIL reserved_op got v=%b e=%b r=%h want 1/1/00", resValid, error, result);
    end
    accept_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_sub_hold();
    test_mem();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
